// File: rtl/hazard_forward_unit_pkg.sv
// Shared types for the hazard/forward control block: shadow pipeline entry, PC and operand selects.
// Entry address fields are sized by PKG_REG_AW; the top-level REG_AW must match it.
package hazard_forward_unit_pkg;

    localparam int PKG_REG_AW = 5;

    typedef logic [PKG_REG_AW-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

    typedef struct packed {
        logic      valid;
        logic      reg_write;
        logic      mem_read;
        reg_addr_t dst;
        reg_addr_t rs;
        reg_addr_t rt;
    } shadow_entry_t;

    typedef enum logic [1:0] {
        PC_INC = 2'd0,
        PC_BR  = 2'd1,
        PC_JMP = 2'd2
    } pc_src_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    // A live producer of r; register 0 is hard-wired and never produces anything.
    function automatic logic reg_match(input logic valid, input logic reg_write,
                                       input reg_addr_t dst, input reg_addr_t r);
        return valid && reg_write && (dst != REG_ZERO) && (dst == r);
    endfunction

endpackage

// File: rtl/hazard_forward_unit_if.sv
// ID-stage decode inputs and PC/IF-ID/ID-EX/ALU-mux controls between pipeline datapath and hazard unit.
// master = datapath side (drives decode info), slave = hazard_forward_unit.
interface hazard_forward_unit_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic [REG_AW-1:0] id_dst;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              id_is_branch;
    logic              id_is_jump;
    logic              equal;

    logic [1:0]        pc_src;
    logic              pc_write;
    logic              ifid_write;
    logic              if_flush;
    logic              control_sel;
    logic [1:0]        a_sel;
    logic [1:0]        b_sel;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_dst, id_reg_write, id_mem_read,
               id_is_branch, id_is_jump, equal,
        input  pc_src, pc_write, ifid_write, if_flush, control_sel, a_sel, b_sel,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_dst, id_reg_write, id_mem_read,
               id_is_branch, id_is_jump, equal,
        output pc_src, pc_write, ifid_write, if_flush, control_sel, a_sel, b_sel,
               stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_forward_unit_fwd_select.sv
// ALU operand source for one EX source register: MEM ALU result beats WB, loads in MEM never forward.
// Purely combinational.
module hazard_forward_unit_fwd_select
    import hazard_forward_unit_pkg::*;
(
    input  shadow_entry_t mem_entry_i,
    input  shadow_entry_t wb_entry_i,
    input  reg_addr_t     src_i,
    output fwd_sel_e      sel_o
);

    logic mem_hit;
    logic wb_hit;
    logic unused_fields;

    assign mem_hit = reg_match(mem_entry_i.valid, mem_entry_i.reg_write, mem_entry_i.dst, src_i);
    assign wb_hit  = reg_match(wb_entry_i.valid, wb_entry_i.reg_write, wb_entry_i.dst, src_i);

    assign unused_fields = ^{mem_entry_i.rs, mem_entry_i.rt,
                             wb_entry_i.mem_read, wb_entry_i.rs, wb_entry_i.rt};

    always_comb begin
        sel_o = FWD_REG;
        if (mem_hit && !mem_entry_i.mem_read) begin
            sel_o = FWD_MEM;
        end else if (wb_hit) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection, branch/jump redirect and EX forwarding driven from a shadow EX/MEM/WB pipe.
// Outputs are combinational (zero latency); HAZ_PERF_CNT_EN builds saturating stall/flush counters.
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int REG_AW = PKG_REG_AW,
    parameter int CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    hazard_forward_unit_if.slave  hif
);

    logic [REG_AW-1:0] id_rs_w;
    logic [REG_AW-1:0] id_rt_w;
    logic [REG_AW-1:0] id_dst_w;

    shadow_entry_t id_entry;
    shadow_entry_t ex_q, mem_q, wb_q;
    shadow_entry_t ex_d, mem_d, wb_d;

    logic     hit_ex;
    logic     hit_mem;
    logic     load_use;
    logic     branch_stall;
    logic     stall;
    fwd_sel_e a_fwd;
    fwd_sel_e b_fwd;

    logic     pc_write_o;
    logic     ifid_write_o;
    logic     if_flush_o;
    logic     control_sel_o;
    pc_src_e  pc_src_o;
    fwd_sel_e a_sel_o;
    fwd_sel_e b_sel_o;

    assign id_rs_w  = hif.id_rs;
    assign id_rt_w  = hif.id_rt;
    assign id_dst_w = hif.id_dst;

    always_comb begin
        id_entry           = '0;
        id_entry.valid     = 1'b1;
        id_entry.reg_write = hif.id_reg_write;
        id_entry.mem_read  = hif.id_mem_read;
        id_entry.dst       = id_dst_w;
        id_entry.rs        = id_rs_w;
        id_entry.rt        = id_rt_w;
    end

    assign hit_ex  = (hif.id_use_rs && reg_match(ex_q.valid, ex_q.reg_write, ex_q.dst, id_rs_w)) ||
                     (hif.id_use_rt && reg_match(ex_q.valid, ex_q.reg_write, ex_q.dst, id_rt_w));
    assign hit_mem = (hif.id_use_rs && reg_match(mem_q.valid, mem_q.reg_write, mem_q.dst, id_rs_w)) ||
                     (hif.id_use_rt && reg_match(mem_q.valid, mem_q.reg_write, mem_q.dst, id_rt_w));

    // Branch compares in ID with no forwarding: any producer still in EX or MEM must first reach WB,
    // where the write-first register file makes it visible.
    assign load_use     = ex_q.mem_read && hit_ex;
    assign branch_stall = hif.id_is_branch && (hit_ex || hit_mem);
    assign stall        = load_use || branch_stall;

    always_comb begin
        wb_d  = mem_q;
        mem_d = ex_q;
        ex_d  = stall ? shadow_entry_t'('0) : id_entry;
        if (rst) begin
            wb_d  = '0;
            mem_d = '0;
            ex_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        ex_q  <= ex_d;
        mem_q <= mem_d;
        wb_q  <= wb_d;
    end

    hazard_forward_unit_fwd_select u_fwd_a (
        .mem_entry_i (mem_q),
        .wb_entry_i  (wb_q),
        .src_i       (ex_q.rs),
        .sel_o       (a_fwd)
    );

    hazard_forward_unit_fwd_select u_fwd_b (
        .mem_entry_i (mem_q),
        .wb_entry_i  (wb_q),
        .src_i       (ex_q.rt),
        .sel_o       (b_fwd)
    );

    always_comb begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        control_sel_o = 1'b1;
        if_flush_o    = 1'b0;
        pc_src_o      = PC_INC;
        a_sel_o       = a_fwd;
        b_sel_o       = b_fwd;
        if (rst) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            control_sel_o = 1'b0;
            if_flush_o    = 1'b1;
            a_sel_o       = FWD_REG;
            b_sel_o       = FWD_REG;
        end else if (stall) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            control_sel_o = 1'b0;
        end else if (hif.id_is_branch && hif.equal) begin
            pc_src_o   = PC_BR;
            if_flush_o = 1'b1;
        end else if (hif.id_is_jump) begin
            pc_src_o   = PC_JMP;
            if_flush_o = 1'b1;
        end
    end

    assign hif.pc_write    = pc_write_o;
    assign hif.ifid_write  = ifid_write_o;
    assign hif.control_sel = control_sel_o;
    assign hif.if_flush    = if_flush_o;
    assign hif.pc_src      = pc_src_o;
    assign hif.a_sel       = a_sel_o;
    assign hif.b_sel       = b_sel_o;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    assign stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    assign flush_cnt_d = (if_flush_o && !(&flush_cnt_q)) ? flush_cnt_q + 1'b1 : flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hif.stall_cnt = stall_cnt_q;
    assign hif.flush_cnt = flush_cnt_q;
`else
    assign hif.stall_cnt = {CNT_W{1'b0}};
    assign hif.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule
